// File: rtl/nio2_sys_onchip_mem_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves (s1 = CPU, s2 = DMA).
// Byte-enabled writes, pipelined read responses of READ_LATENCY (1 or 2)
// cycles, and s1-wins collision handling with a saturating drop counter.
module nio2_sys_onchip_mem_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "nio2_sys_onchip_mem.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    collision,
  output logic [15:0]             collision_count
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 32'd1 << ADDR_WIDTH;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Storage array; contents survive reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Initial contents come from INIT_FILE through the device memory-init flow.
  if (INIT_FILE == "") begin : g_no_init_file
  end

  logic en_c;
  logic wr1_c;
  logic wr2_c;
  logic rd1_c;
  logic rd2_c;
  logic coll_c;

  // Response pipeline: stage 1 is the RAM output register, stage 2 the extra
  // output register used when READ_LATENCY is 2. Index 0 = s1, index 1 = s2.
  logic [1:0]                 vld1_q, vld1_d;
  logic [1:0]                 vld2_q, vld2_d;
  logic [1:0][DATA_WIDTH-1:0] dat1_q, dat1_d;
  logic [1:0][DATA_WIDTH-1:0] dat2_q, dat2_d;
  logic                       coll_q, coll_d;
  logic [15:0]                cnt_q, cnt_d;

  // Request decode; requests in the reset cycle are ignored.
  assign en_c   = clken & ~reset_req;
  assign wr1_c  = s1_chipselect & s1_write & en_c & ~reset;
  assign wr2_c  = s2_chipselect & s2_write & en_c & ~reset;
  assign rd1_c  = s1_chipselect & s1_read & ~s1_write & en_c & ~reset;
  assign rd2_c  = s2_chipselect & s2_read & ~s2_write & en_c & ~reset;
  assign coll_c = wr1_c & wr2_c & (s1_address == s2_address) &
                  (|(s1_byteenable & s2_byteenable));

  // Next-state for response pipeline and collision reporting.
  always_comb begin
    vld1_d = vld1_q;
    vld2_d = vld2_q;
    dat1_d = dat1_q;
    dat2_d = dat2_q;
    coll_d = coll_c;
    cnt_d  = cnt_q;
    if (en_c) begin
      vld1_d = {rd2_c, rd1_c};
      vld2_d = vld1_q;
      dat2_d = dat1_q;
      if (rd1_c) begin
        dat1_d[0] = mem_q[s1_address];
      end
      if (rd2_c) begin
        dat1_d[1] = mem_q[s2_address];
      end
    end
    if (coll_c && (cnt_q != COUNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Pipeline and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld1_q <= '0;
      vld2_q <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld1_q <= vld1_d;
      vld2_q <= vld2_d;
      dat1_q <= dat1_d;
      dat2_q <= dat2_d;
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  // Lane-wise writes; a colliding s2 write is dropped so s1 always wins.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (wr2_c && !coll_c && s2_byteenable[b]) begin
        mem_q[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
      if (wr1_c && s1_byteenable[b]) begin
        mem_q[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  assign s1_readdata      = (READ_LATENCY == 2) ? dat2_q[0] : dat1_q[0];
  assign s2_readdata      = (READ_LATENCY == 2) ? dat2_q[1] : dat1_q[1];
  assign s1_readdatavalid = (READ_LATENCY == 2) ? vld2_q[0] : vld1_q[0];
  assign s2_readdatavalid = (READ_LATENCY == 2) ? vld2_q[1] : vld1_q[1];
  assign collision        = coll_q;
  assign collision_count  = cnt_q;

endmodule

// File: tb/tb_nio2_sys_onchip_mem_dp.sv
// Bench for nio2_sys_onchip_mem_dp: one latency-1 and one latency-2 instance
// share all stimulus; read responses are scoreboarded with data and due edge.
module tb_nio2_sys_onchip_mem_dp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 4;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;
  localparam logic [1:0] OP_RW   = 2'd3;

  typedef struct {
    logic [1:0]    op1;
    logic [AW-1:0] a1;
    logic [BW-1:0] be1;
    logic [DW-1:0] d1;
    logic [DW-1:0] x1;
    logic [1:0]    op2;
    logic [AW-1:0] a2;
    logic [BW-1:0] be2;
    logic [DW-1:0] d2;
    logic [DW-1:0] x2;
    logic          coll;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  logic [AW-1:0] s1_address = '0, s2_address = '0;
  logic [BW-1:0] s1_byteenable = '0, s2_byteenable = '0;
  logic s1_chipselect = 1'b0, s2_chipselect = 1'b0;
  logic s1_read = 1'b0, s2_read = 1'b0;
  logic s1_write = 1'b0, s2_write = 1'b0;
  logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;

  // k = 0: L1 s1, 1: L1 s2, 2: L2 s1, 3: L2 s2
  logic [DW-1:0] rdata [4];
  logic          vld   [4];
  logic          coll  [2];
  logic [15:0]   ccnt  [2];

  exp_t        exp_q [4][$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  vec_t        vt [17];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nio2_sys_onchip_mem_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("nio2_sys_onchip_mem.hex")
  ) u_l1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(rdata[0]), .s1_readdatavalid(vld[0]),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(rdata[1]), .s2_readdatavalid(vld[1]),
    .collision(coll[0]), .collision_count(ccnt[0])
  );

  nio2_sys_onchip_mem_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("nio2_sys_onchip_mem.hex")
  ) u_l2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(rdata[2]), .s1_readdatavalid(vld[2]),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(rdata[3]), .s2_readdatavalid(vld[3]),
    .collision(coll[1]), .collision_count(ccnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (edge %0d)", name, act, want, cyc);
  endtask

  // Responses are consumed at enabled edges, as a clock-enabled master would.
  always @(negedge clk) begin
    if (clken && !reset_req) begin
      for (int k = 0; k < 4; k++) begin
        if (vld[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid[%0d]: got valid=1, want 0 (edge %0d)", k, cyc + 1);
          end else begin
            exp_t e;
            e = exp_q[k].pop_front();
            check($sformatf("rdata[%0d]", k), rdata[k], e.data);
            check($sformatf("resp_edge[%0d]", k), 32'(cyc + 1), 32'(e.due));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [1:0] op1, input logic [AW-1:0] a1, input logic [BW-1:0] be1,
                              input logic [DW-1:0] d1, input logic [DW-1:0] x1,
                              input logic [1:0] op2, input logic [AW-1:0] a2, input logic [BW-1:0] be2,
                              input logic [DW-1:0] d2, input logic [DW-1:0] x2, input logic c);
    vec_t v;
    v.op1 = op1; v.a1 = a1; v.be1 = be1; v.d1 = d1; v.x1 = x1;
    v.op2 = op2; v.a2 = a2; v.be2 = be2; v.d2 = d2; v.x2 = x2;
    v.coll = c;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  // Read accepted at the next edge (cyc+1); response due L edges later plus stall.
  task automatic push(input int port, input logic [DW-1:0] data, input int unsigned extra, input bit l1, input bit l2);
    exp_t e;
    e.data = data;
    if (l1) begin e.due = cyc + 2 + extra; exp_q[port].push_back(e); end
    if (l2) begin e.due = cyc + 3 + extra; exp_q[port + 2].push_back(e); end
  endtask

  task automatic apply(input vec_t v);
    s1_chipselect = |v.op1; s1_write = v.op1[0]; s1_read = v.op1[1];
    s1_address = v.a1; s1_byteenable = v.be1; s1_writedata = v.d1;
    s2_chipselect = |v.op2; s2_write = v.op2[0]; s2_read = v.op2[1];
    s2_address = v.a2; s2_byteenable = v.be2; s2_writedata = v.d2;
    if (v.op1 == OP_RD) push(0, v.x1, 0, 1'b1, 1'b1);
    if (v.op2 == OP_RD) push(1, v.x2, 0, 1'b1, 1'b1);
  endtask

  task automatic check_status(input string tag, input logic c, input logic [15:0] cnt);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_collision[%0d]", tag, i), 32'(coll[i]), 32'(c));
      check($sformatf("%s_count[%0d]", tag, i), 32'(ccnt[i]), 32'(cnt));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_rdata[%0d]", tag, k), rdata[k], 32'h0);
      check($sformatf("%s_valid[%0d]", tag, k), 32'(vld[k]), 32'h0);
    end
  endtask

  initial begin
    int seen;

    // Reset state
    step(); step();
    check_outputs_zero("reset");
    check_status("reset", 1'b0, 16'h0);
    reset = 1'b0;

    vt[0]  = mk(OP_WR,   5, 4'hF, 32'hDEADBEEF, 0,            OP_IDLE, 0,  4'h0, 0,            0,            1'b0);
    vt[1]  = mk(OP_IDLE, 0, 4'h0, 0,            0,            OP_RD,   5,  4'h0, 0,            32'hDEADBEEF, 1'b0);
    vt[2]  = mk(OP_WR,  10, 4'hF, 32'h11223344, 0,            OP_IDLE, 0,  4'h0, 0,            0,            1'b0);
    vt[3]  = mk(OP_WR,  10, 4'h5, 32'hAABBCCDD, 0,            OP_IDLE, 0,  4'h0, 0,            0,            1'b0);
    vt[4]  = mk(OP_RD,  10, 4'h0, 0,            32'h11BB33DD, OP_IDLE, 0,  4'h0, 0,            0,            1'b0);
    vt[5]  = mk(OP_WR,   7, 4'hF, 32'h1,        0,            OP_WR,   7,  4'hF, 32'h2,        0,            1'b1);
    vt[6]  = mk(OP_RD,   7, 4'h0, 0,            32'h1,        OP_RD,   5,  4'h0, 0,            32'hDEADBEEF, 1'b0);
    vt[7]  = mk(OP_WR,   8, 4'h3, 32'h0000BEEF, 0,            OP_WR,   8,  4'hC, 32'hCAFE0000, 0,            1'b0);
    vt[8]  = mk(OP_RD,   8, 4'h0, 0,            32'hCAFEBEEF, OP_IDLE, 0,  4'h0, 0,            0,            1'b0);
    vt[9]  = mk(OP_WR,   3, 4'hF, 32'h99,       0,            OP_IDLE, 0,  4'h0, 0,            0,            1'b0);
    vt[10] = mk(OP_WR,   3, 4'hF, 32'h55,       0,            OP_RD,   3,  4'h0, 0,            32'h99,       1'b0);
    vt[11] = mk(OP_IDLE, 0, 4'h0, 0,            0,            OP_RD,   3,  4'h0, 0,            32'h55,       1'b0);
    vt[12] = mk(OP_WR,  20, 4'hF, 32'h12345678, 0,            OP_WR,  20,  4'h0, 32'hFFFFFFFF, 0,            1'b0);
    vt[13] = mk(OP_RD,  20, 4'h0, 0,            32'h12345678, OP_WR,  21,  4'hF, 32'h87654321, 0,            1'b0);
    vt[14] = mk(OP_RW,  22, 4'hF, 32'hABCD0001, 0,            OP_RD,  21,  4'h0, 0,            32'h87654321, 1'b0);
    vt[15] = mk(OP_RD,  22, 4'h0, 0,            32'hABCD0001, OP_RD,  20,  4'h0, 0,            32'h12345678, 1'b0);
    vt[16] = mk(OP_RD,  10, 4'h0, 0,            32'h11BB33DD, OP_RD,   7,  4'h0, 0,            32'h1,        1'b0);

    for (int i = 0; i < 17; i++) begin
      apply(vt[i]);
      step();
      for (int j = 0; j < 2; j++)
        check($sformatf("vec%0d_collision[%0d]", i, j), 32'(coll[j]), 32'(vt[i].coll));
    end
    idle();
    repeat (4) step();
    check_status("after_table", 1'b0, 16'h1);

    // Saturating collision counter
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 7; s1_byteenable = 4'hF; s1_writedata = 32'h1;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 7; s2_byteenable = 4'hF; s2_writedata = 32'h2;
    repeat (32'hFFFD) step();
    check_status("sat_fffe", 1'b1, 16'hFFFE);
    step();
    check_status("sat_ffff", 1'b1, 16'hFFFF);
    step();
    check_status("sat_hold", 1'b1, 16'hFFFF);
    idle();
    step();
    check_status("sat_idle", 1'b0, 16'hFFFF);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 7;
    push(0, 32'h1, 0, 1'b1, 1'b1);
    step();
    idle();
    repeat (4) step();

    // Stall by clken (v=0) and by reset_req (v=1)
    for (int v = 0; v < 2; v++) begin
      s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 5;
      push(1, 32'hDEADBEEF, 3, 1'b1, 1'b1);
      step();
      idle();
      if (v == 0) clken = 1'b0; else reset_req = 1'b1;
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 5;  s1_byteenable = 4'hF; s1_writedata = 32'h0;
      s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 10; s2_byteenable = 4'hF; s2_writedata = 32'h0;
      repeat (3) step();
      clken = 1'b1; reset_req = 1'b0;
      idle();
      repeat (5) step();
    end
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 5;
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 10;
    push(0, 32'hDEADBEEF, 0, 1'b1, 1'b1);
    push(1, 32'h11BB33DD, 0, 1'b1, 1'b1);
    step();
    idle();
    repeat (4) step();

    // Reset mid-operation
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 40; s1_byteenable = 4'hF; s1_writedata = 32'h0BADF00D;
    step();
    idle();
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 40;
    push(0, 32'h0BADF00D, 0, 1'b1, 1'b0);
    step();
    idle();
    reset = 1'b1;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 40; s2_byteenable = 4'hF; s2_writedata = 32'hFFFFFFFF;
    step();
    reset = 1'b0;
    idle();
    check_outputs_zero("post_reset");
    check_status("post_reset", 1'b0, 16'h0);
    seen = 0;
    repeat (5) begin
      step();
      if (vld[2] === 1'b1) seen++;
    end
    check("reset_dropped_resp", 32'(seen), 32'h0);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 40;
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 10;
    push(0, 32'h0BADF00D, 0, 1'b1, 1'b1);
    push(1, 32'h11BB33DD, 0, 1'b1, 1'b1);
    step();
    idle();
    repeat (5) step();

    for (int k = 0; k < 4; k++)
      check($sformatf("pending_resp[%0d]", k), 32'(exp_q[k].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
